i2c_lut_cfg_sequencer: RTL and testbench

Parametrised I2C configuration sequencer that walks a combinational register LUT and issues one I2C register write per entry through a byte-level I2C master. It adds the following:
- programmable register-address width (8/16-bit);
- a power-up delay;
- in-table delay entries;
- bounded NACK retry;
- restart on demand;
- done/error status with the failing index.

It sits between a device config LUT (ADV7611, sensors) and the shared I2C master.

---
 rtl/i2c_lut_cfg_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_lut_cfg_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_lut_cfg_sequencer.sv
// I2C configuration sequencer.
// Walks a combinational register LUT and issues one I2C register write per
// entry through a byte-level I2C master. It also supports a power-up delay,
// in-table delay entries, bounded NACK retry and restart-on-demand.
module i2c_lut_cfg_sequencer #(
    parameter int           INDEX_W   = 9,
    parameter int           REG_W     = 8,
    parameter int           PWRUP_DLY = 1_000_000,
    parameter int           DLY_UNIT  = 50_000,
    parameter logic [7:0]   DELAY_TAG = 8'hFF,
    parameter int           MAX_RETRY = 3,
    parameter int           RETRY_GAP = 10_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [INDEX_W-1:0]    lut_size,
    output logic [INDEX_W-1:0]    lut_index,
    input  logic [REG_W+15:0]     lut_data,
    output logic                  i2c_req,
    output logic [7:0]            i2c_dev,
    output logic [REG_W-1:0]      i2c_reg,
    output logic [7:0]            i2c_wdata,
    input  logic                  i2c_done,
    input  logic                  i2c_nack,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic [INDEX_W-1:0]    err_index
);

    // One shared counter serves the power-up wait, the retry gap and delay
    // entries; it is sized for the largest of the three.
    localparam int DLY_MAX = 255 * DLY_UNIT;
    localparam int CNT_MAX = (PWRUP_DLY > RETRY_GAP)
                           ? ((PWRUP_DLY > DLY_MAX) ? PWRUP_DLY : DLY_MAX)
                           : ((RETRY_GAP > DLY_MAX) ? RETRY_GAP : DLY_MAX);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST = (PWRUP_DLY > 0) ? CNT_W'(PWRUP_DLY - 1) : '0;
    localparam logic [CNT_W-1:0] GAP_LAST   = (RETRY_GAP > 0) ? CNT_W'(RETRY_GAP - 1) : '0;
    localparam logic [RTY_W-1:0] RTY_LAST   = RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_PWRUP, S_FETCH, S_LATCH, S_ISSUE, S_WAIT,
        S_DELAY, S_GAP, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [RTY_W-1:0]     retry_q;
    logic [INDEX_W-1:0]   index_q;
    logic [INDEX_W-1:0]   eidx_q;
    logic                 req_q;
    logic [7:0]           dev_q;
    logic [REG_W-1:0]     reg_q;
    logic [7:0]           wdata_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    // LUT word fields: {dev, reg, data}.
    logic [7:0]           lut_dev;
    logic [REG_W-1:0]     lut_reg;
    logic [7:0]           lut_wd;
    logic [CNT_W-1:0]     dly_cnt;
    logic [INDEX_W-1:0]   last_index;

    assign lut_dev    = lut_data[REG_W+15:REG_W+8];
    assign lut_reg    = lut_data[REG_W+7:8];
    assign lut_wd     = lut_data[7:0];
    assign dly_cnt    = CNT_W'(lut_wd) * CNT_W'(DLY_UNIT);
    assign last_index = lut_size - 1'b1;

    // Sequencer FSM; every output comes straight from a register.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            retry_q <= '0;
            index_q <= '0;
            eidx_q  <= '0;
            req_q   <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_PWRUP: begin
                    busy_q <= 1'b1;
                    if (cnt_q >= PWRUP_LAST) begin
                        cnt_q <= '0;
                        if (lut_size == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FETCH: state_q <= S_LATCH;
                S_LATCH: begin
                    if (lut_dev == DELAY_TAG) begin
                        cnt_q   <= dly_cnt;
                        state_q <= S_DELAY;
                    end else begin
                        dev_q   <= lut_dev;
                        reg_q   <= lut_reg;
                        wdata_q <= lut_wd;
                        state_q <= S_ISSUE;
                    end
                end
                S_DELAY: begin
                    // A zero count still spends one cycle here.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= S_NEXT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_ISSUE: begin
                    req_q   <= 1'b1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i2c_done) begin
                        req_q <= 1'b0;
                        if (!i2c_nack) begin
                            retry_q <= '0;
                            state_q <= S_NEXT;
                        end else if (retry_q < RTY_LAST) begin
                            retry_q <= retry_q + 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_GAP;
                        end else begin
                            eidx_q  <= index_q;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_ERR;
                        end
                    end
                end
                S_GAP: begin
                    // Re-issue the already latched fields; no re-fetch.
                    if (cnt_q >= GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_ISSUE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (index_q == last_index) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        index_q <= index_q + 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_DONE, S_ERR: begin
                    // Restart skips the power-up wait.
                    if (start) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        eidx_q  <= '0;
                        retry_q <= '0;
                        index_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_PWRUP;
            endcase
        end
    end

    assign lut_index = index_q;
    assign i2c_req   = req_q;
    assign i2c_dev   = dev_q;
    assign i2c_reg   = reg_q;
    assign i2c_wdata = wdata_q;
    assign busy      = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_index = eidx_q;

endmodule

// File: tb/tb_i2c_lut_cfg_sequencer.sv
// Directed bench for i2c_lut_cfg_sequencer: one REG_W=8 and one REG_W=16
// instance share a modelled I2C master selected by 'sel'.
module tb_i2c_lut_cfg_sequencer;

    localparam int INDEX_W = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel   = 1'b0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // REG_W = 8 instance
    logic [INDEX_W-1:0] a_size, a_index, a_eidx;
    logic [23:0]        a_lut_data;
    logic               a_req, a_done, a_nack, a_busy, a_cdone, a_cerr;
    logic [7:0]         a_dev, a_reg, a_wdata;
    logic [23:0]        a_lut [512];
    assign a_lut_data = a_lut[a_index];

    i2c_lut_cfg_sequencer #(
        .INDEX_W(INDEX_W), .REG_W(8), .PWRUP_DLY(16), .DLY_UNIT(4),
        .DELAY_TAG(8'hFF), .MAX_RETRY(2), .RETRY_GAP(5)
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .lut_size(a_size),
        .lut_index(a_index), .lut_data(a_lut_data), .i2c_req(a_req),
        .i2c_dev(a_dev), .i2c_reg(a_reg), .i2c_wdata(a_wdata),
        .i2c_done(a_done), .i2c_nack(a_nack), .busy(a_busy),
        .cfg_done(a_cdone), .cfg_err(a_cerr), .err_index(a_eidx)
    );

    // REG_W = 16 instance
    logic [INDEX_W-1:0] b_size, b_index, b_eidx;
    logic [31:0]        b_lut_data;
    logic               b_req, b_done, b_nack, b_busy, b_cdone, b_cerr;
    logic [7:0]         b_dev, b_wdata;
    logic [15:0]        b_reg;
    logic [31:0]        b_lut [512];
    assign b_lut_data = b_lut[b_index];

    i2c_lut_cfg_sequencer #(
        .INDEX_W(INDEX_W), .REG_W(16), .PWRUP_DLY(16), .DLY_UNIT(4),
        .DELAY_TAG(8'hFF), .MAX_RETRY(2), .RETRY_GAP(5)
    ) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .lut_size(b_size),
        .lut_index(b_index), .lut_data(b_lut_data), .i2c_req(b_req),
        .i2c_dev(b_dev), .i2c_reg(b_reg), .i2c_wdata(b_wdata),
        .i2c_done(b_done), .i2c_nack(b_nack), .busy(b_busy),
        .cfg_done(b_cdone), .cfg_err(b_cerr), .err_index(b_eidx)
    );

    // Selected instance view
    logic               m_req, m_busy, m_cdone, m_cerr;
    logic [7:0]         m_dev, m_wdata;
    logic [15:0]        m_reg;
    logic [INDEX_W-1:0] m_index, m_eidx;
    assign m_req   = sel ? b_req   : a_req;
    assign m_dev   = sel ? b_dev   : a_dev;
    assign m_reg   = sel ? b_reg   : {8'h00, a_reg};
    assign m_wdata = sel ? b_wdata : a_wdata;
    assign m_index = sel ? b_index : a_index;
    assign m_eidx  = sel ? b_eidx  : a_eidx;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_cdone = sel ? b_cdone : a_cdone;
    assign m_cerr  = sel ? b_cerr  : a_cerr;

    // Master model: done 10 cycles after req, NACKs entry nack_idx up to nack_limit times
    logic m_done, m_nack;
    int   m_wcnt, nack_given;
    int   nack_idx = -1;
    int   nack_limit = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_done <= 1'b0; m_nack <= 1'b0; m_wcnt <= 0; nack_given <= 0;
        end else begin
            m_done <= 1'b0;
            m_nack <= 1'b0;
            if (m_req && !m_done) begin
                if (m_wcnt == 9) begin
                    m_done <= 1'b1;
                    m_wcnt <= 0;
                    if (int'(m_index) == nack_idx && nack_given < nack_limit) begin
                        m_nack     <= 1'b1;
                        nack_given <= nack_given + 1;
                    end
                end else begin
                    m_wcnt <= m_wcnt + 1;
                end
            end else begin
                m_wcnt <= 0;
            end
        end
    end
    assign a_done = m_done & ~sel;
    assign b_done = m_done & sel;
    assign a_nack = m_nack;
    assign b_nack = m_nack;

    // Request / completion monitor (cycle stamps are posedge numbers)
    int          rq_cyc[$];
    int          rq_idx[$];
    logic [7:0]  rq_dev[$];
    logic [15:0] rq_reg[$];
    logic [7:0]  rq_dat[$];
    int          dn_cyc[$];
    int          hold_err = 0;
    logic        m_req_prev = 1'b0;
    always @(negedge clk) begin
        if (m_req && !m_req_prev) begin
            rq_cyc.push_back(cyc);
            rq_idx.push_back(int'(m_index));
            rq_dev.push_back(m_dev);
            rq_reg.push_back(m_reg);
            rq_dat.push_back(m_wdata);
        end else if (m_req && m_req_prev && rq_dev.size() > 0) begin
            if (m_dev != rq_dev[$] || m_reg != rq_reg[$] || m_wdata != rq_dat[$])
                hold_err <= hold_err + 1;
        end
        if (m_done) dn_cyc.push_back(cyc + 1);
        m_req_prev <= m_req;
    end

    int n_total = 0;
    int n_bad   = 0;
    int rel     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rq_cyc.delete(); rq_idx.delete(); rq_dev.delete();
        rq_reg.delete(); rq_dat.delete(); dn_cyc.delete();
        hold_err = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        rel   = cyc;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(m_cdone || m_cerr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", {31'd0, m_cdone | m_cerr}, 32'd1);
    endtask

    task automatic wait_req(input int cnt, input int budget);
        int n = 0;
        while (rq_cyc.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, rq_cyc.size() >= cnt}, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int s;
        for (int i = 0; i < 512; i++) begin
            a_lut[i] = 24'h0;
            b_lut[i] = 32'h0;
        end
        a_lut[0] = {8'h42, 8'h10, 8'hA1};
        a_lut[1] = {8'h42, 8'h11, 8'hB2};
        a_lut[2] = {8'h43, 8'h20, 8'hC3};
        a_lut[3] = {8'h44, 8'h7F, 8'h00};
        b_lut[0] = {8'h20, 16'h3012, 8'h55};
        b_lut[1] = {8'hFF, 16'h0000, 8'h03};
        b_lut[2] = {8'h20, 16'h3014, 8'hAA};
        a_size = 9'd4;
        b_size = 9'd3;

        // Nominal REG_W=8, with a start pulse while busy
        sel = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req",   {31'd0, a_req},   32'd0);
        check("rst_busy",  {31'd0, a_busy},  32'd0);
        check("rst_done",  {31'd0, a_cdone}, 32'd0);
        check("rst_err",   {31'd0, a_cerr},  32'd0);
        check("rst_index", 32'(a_index),     32'd0);
        check("rst_fields", {a_dev, a_reg, a_wdata}, 32'd0);
        do_reset();
        @(negedge clk);
        check("busy_after_rst", {31'd0, a_busy}, 32'd1);
        wait_req(1, 100);
        pulse_start();
        wait_end(500);
        check("nom_nreq",   32'(rq_cyc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("nom_idx", 32'(rq_idx[i]), 32'(i));
            check("nom_dev", 32'(rq_dev[i]), 32'(a_lut[i][23:16]));
            check("nom_reg", 32'(rq_reg[i]), 32'(a_lut[i][15:8]));
            check("nom_dat", 32'(rq_dat[i]), 32'(a_lut[i][7:0]));
        end
        check("nom_first_req", 32'(rq_cyc[0] - rel), 32'd19);
        check("nom_next_gap",  32'(rq_cyc[1] - dn_cyc[0]), 32'd4);
        check("nom_hold",      32'(hold_err), 32'd0);
        check("nom_done",  {31'd0, a_cdone}, 32'd1);
        check("nom_busy",  {31'd0, a_busy},  32'd0);
        check("nom_index", 32'(a_index),     32'd3);

        // REG_W=16 with a delay entry
        sel = 1'b1;
        do_reset();
        wait_end(500);
        check("d16_nreq", 32'(rq_cyc.size()), 32'd2);
        check("d16_reg0", 32'(rq_reg[0]), 32'h3012);
        check("d16_dat0", 32'(rq_dat[0]), 32'h55);
        check("d16_reg1", 32'(rq_reg[1]), 32'h3014);
        check("d16_dat1", 32'(rq_dat[1]), 32'hAA);
        check("d16_delay_gap", 32'(rq_cyc[1] - dn_cyc[0]), 32'd19);
        check("d16_done",  {31'd0, b_cdone}, 32'd1);
        check("d16_index", 32'(b_index),     32'd2);

        // Retry recovery: entry 1 NACKs twice
        sel = 1'b0;
        nack_idx = 1; nack_limit = 2;
        do_reset();
        wait_end(800);
        check("rty_nreq", 32'(rq_cyc.size()), 32'd6);
        for (int i = 1; i <= 3; i++) begin
            check("rty_idx", 32'(rq_idx[i]), 32'd1);
            check("rty_fields", {8'h00, rq_dev[i], rq_reg[i][7:0], rq_dat[i]}, 32'h0042_11B2);
        end
        check("rty_gap1", 32'(rq_cyc[2] - dn_cyc[1]), 32'd6);
        check("rty_gap2", 32'(rq_cyc[3] - dn_cyc[2]), 32'd6);
        check("rty_done", {31'd0, a_cdone}, 32'd1);
        check("rty_hold", 32'(hold_err), 32'd0);

        // Retry exhaustion: entry 2 always NACKs
        nack_idx = 2; nack_limit = 99;
        do_reset();
        wait_end(800);
        check("exh_err",   {31'd0, a_cerr},  32'd1);
        check("exh_done",  {31'd0, a_cdone}, 32'd0);
        check("exh_busy",  {31'd0, a_busy},  32'd0);
        check("exh_eidx",  32'(a_eidx),      32'd2);
        repeat (50) @(negedge clk);
        check("exh_nreq",  32'(rq_cyc.size()), 32'd5);
        check("exh_last_idx", 32'(rq_idx[4] + rq_idx[3] + rq_idx[2]), 32'd6);

        // Restart from ERR: index 0, no power-up wait
        nack_idx = 100;
        clear_log();
        pulse_start();
        s = cyc;
        check("rs_busy",  {31'd0, a_busy}, 32'd1);
        check("rs_err",   {31'd0, a_cerr}, 32'd0);
        check("rs_eidx",  32'(a_eidx),     32'd0);
        check("rs_index", 32'(a_index),    32'd0);
        wait_end(500);
        check("rs_nreq",  32'(rq_cyc.size()), 32'd4);
        check("rs_first_idx", 32'(rq_idx[0]), 32'd0);
        check("rs_first_lat", 32'(rq_cyc[0] - s), 32'd3);
        check("rs_done",  {31'd0, a_cdone}, 32'd1);

        // Asynchronous reset during WAIT
        do_reset();
        wait_req(1, 100);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, a_req}, 32'd0);
        check("arst_status", {28'd0, a_busy, a_cdone, a_cerr, 1'b0}, 32'd0);
        check("arst_outs", {a_dev, a_reg, a_wdata, 8'h00} | 32'(a_index) | 32'(a_eidx), 32'd0);

        // lut_size = 0
        a_size = 9'd0;
        do_reset();
        repeat (15) @(negedge clk);
        check("zero_done_early", {31'd0, a_cdone}, 32'd0);
        check("zero_busy_early", {31'd0, a_busy},  32'd1);
        @(negedge clk);
        check("zero_done", {31'd0, a_cdone}, 32'd1);
        check("zero_busy", {31'd0, a_busy},  32'd0);
        repeat (30) @(negedge clk);
        check("zero_nreq", 32'(rq_cyc.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
